// File: rtl/ego1_ctrl_pkg.sv
// ego1_ctrl_pkg
// Shared definitions for the EGO1 step sequencer controls.
//   state_t      : FSM encoding (MANUAL / AUTO / HOLD; 2'b11 is never used)
//   DIR_UP/DOWN  : sw_dir meaning (0 = count up, 1 = count down)
//   next_count() : 2-bit modulo-4 up/down step
package ego1_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Natural 2-bit overflow gives the mod-4 wrap in both directions.
  function automatic logic [1:0] next_count(input logic [1:0] cur, input logic dir);
    return (dir == DIR_DOWN) ? (cur - 2'd1) : (cur + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronizes a raw push-button into the cp domain and debounces it.
// The debounced level only follows the synchronized input after the two
// have disagreed for DEB_CYCLES consecutive cycles.
//   cp        : system clock
//   rst_n     : asynchronous active-low reset
//   btn_raw   : bouncy, asynchronous button input
//   btn_level : debounced button level
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic cp,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int              CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] deb_cnt;
  logic          level_q;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // deb_cnt holds the number of mismatch cycles already seen, so the
  // level flips on the DEB_CYCLES-th consecutive mismatch. Any agreeing
  // cycle restarts the run.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      level_q <= 1'b0;
    end else if (sync_q2 != level_q) begin
      if (deb_cnt == DEB_LAST) begin
        level_q <= sync_q2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/step_seq_ctrl.sv
// step_seq_ctrl
// Step sequencer controller: a 2-bit up/down counter advanced either by a
// debounced push-button (MANUAL), a free-running prescaler (AUTO), or not
// at all (HOLD).
//   cp         : system clock
//   rst_n      : asynchronous active-low reset
//   btn_step   : raw step button (asynchronous)
//   sw_dir     : direction switch, 0 = up, 1 = down (asynchronous)
//   sw_auto    : auto-step mode switch (asynchronous)
//   sw_hold    : freeze switch, highest priority (asynchronous)
//   step_pulse : one-cycle step strobe
//   dir_out    : direction of the current (or last) step
//   count      : counter value, updates the cycle after step_pulse
//   wrap_pulse : coincident with step_pulse on 3->0 (up) or 0->3 (down)
//   state      : FSM state (00 MANUAL, 01 AUTO, 10 HOLD)
module step_seq_ctrl
  import ego1_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int AUTO_DIV   = 50000000
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       sw_dir,
  input  logic       sw_auto,
  input  logic       sw_hold,
  output logic       step_pulse,
  output logic       dir_out,
  output logic [1:0] count,
  output logic       wrap_pulse,
  output logic [1:0] state
);

  localparam int            PW         = $clog2(AUTO_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(AUTO_DIV - 1);

  logic          dir_s1, dir_s2;
  logic          auto_s1, auto_s2;
  logic          hold_s1, hold_s2;
  logic          deb_level;
  logic          deb_d1, deb_d2;
  state_t        state_q, state_d;
  logic          step_raw;
  logic          step_prev_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    count_q;
  logic          dir_last_q;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .cp       (cp),
    .rst_n    (rst_n),
    .btn_raw  (btn_step),
    .btn_level(deb_level)
  );

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      dir_s1  <= 1'b0;
      dir_s2  <= 1'b0;
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
      hold_s1 <= 1'b0;
      hold_s2 <= 1'b0;
    end else begin
      dir_s1  <= sw_dir;
      dir_s2  <= dir_s1;
      auto_s1 <= sw_auto;
      auto_s2 <= auto_s1;
      hold_s1 <= sw_hold;
      hold_s2 <= hold_s1;
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the switches every cycle (HOLD > AUTO > MANUAL).
  // The step request looks only at the registered state, so a step landing
  // on a state-change cycle is still emitted. The manual request uses the
  // delayed debounced level so the strobe trails the level change by one
  // cycle; rises seen outside MANUAL simply vanish.
  always_comb begin
    state_d  = ST_MANUAL;
    step_raw = 1'b0;
    if (hold_s2) begin
      state_d = ST_HOLD;
    end else if (auto_s2) begin
      state_d = ST_AUTO;
    end
    case (state_q)
      ST_MANUAL: step_raw = deb_d1 & ~deb_d2;
      ST_AUTO:   step_raw = (presc_q == PRESC_LAST);
      default:   step_raw = 1'b0;
    endcase
  end

  // Guard against a manual and an auto strobe landing back to back across
  // a mode change.
  assign step_pulse = step_raw & ~step_prev_q;
  assign wrap_pulse = step_pulse &
                      ((dir_s2 == DIR_DOWN) ? (count_q == 2'd0) : (count_q == 2'd3));
  assign dir_out    = step_pulse ? dir_s2 : dir_last_q;
  assign count      = count_q;
  assign state      = state_q;

  // Prescaler runs in AUTO, freezes in HOLD so AUTO can resume where it
  // left off, and is held at zero in MANUAL so entry from MANUAL starts
  // a full period.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      case (state_q)
        ST_AUTO: presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        ST_HOLD: presc_q <= presc_q;
        default: presc_q <= '0;
      endcase
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      deb_d1      <= 1'b0;
      deb_d2      <= 1'b0;
      step_prev_q <= 1'b0;
      count_q     <= 2'd0;
      dir_last_q  <= DIR_UP;
    end else begin
      deb_d1      <= deb_level;
      deb_d2      <= deb_d1;
      step_prev_q <= step_pulse;
      if (step_pulse) begin
        count_q    <= next_count(count_q, dir_s2);
        dir_last_q <= dir_s2;
      end
    end
  end

endmodule

// File: tb/tb_step_seq_ctrl.sv
// tb_step_seq_ctrl
// Directed bench for step_seq_ctrl with DEB_CYCLES=4, AUTO_DIV=8.
// Inputs change 1 time unit after a rising edge; outputs are read there or
// on the falling edge. cyc is the number of rising edges seen so far.
module tb_step_seq_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;

  logic       cp       = 1'b0;
  logic       rst_n    = 1'b1;
  logic       btn_step = 1'b0;
  logic       sw_dir   = 1'b0;
  logic       sw_auto  = 1'b0;
  logic       sw_hold  = 1'b0;
  logic       step_pulse;
  logic       dir_out;
  logic [1:0] count;
  logic       wrap_pulse;
  logic [1:0] state;

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int step_cnt   = 0;
  int wrap_cnt   = 0;
  int consec_cnt = 0;
  logic prev_step = 1'b0;
  logic prev_wrap = 1'b0;

  step_seq_ctrl #(
    .DEB_CYCLES(DEB),
    .AUTO_DIV  (DIV)
  ) dut (
    .cp        (cp),
    .rst_n     (rst_n),
    .btn_step  (btn_step),
    .sw_dir    (sw_dir),
    .sw_auto   (sw_auto),
    .sw_hold   (sw_hold),
    .step_pulse(step_pulse),
    .dir_out   (dir_out),
    .count     (count),
    .wrap_pulse(wrap_pulse),
    .state     (state)
  );

  always #5 cp = ~cp;

  always @(posedge cp) cyc <= cyc + 1;

  // Strobe bookkeeping sampled mid-cycle.
  always @(negedge cp) begin
    if (step_pulse === 1'b1) step_cnt++;
    if (wrap_pulse === 1'b1) wrap_cnt++;
    if ((step_pulse === 1'b1 && prev_step === 1'b1) ||
        (wrap_pulse === 1'b1 && prev_wrap === 1'b1)) consec_cnt++;
    prev_step = step_pulse;
    prev_wrap = wrap_pulse;
  end

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_step: got %b expected 0", step_pulse); end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrap_pulse); end
    checks++; if (dir_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_dir: got %b expected 0", dir_out); end
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %b expected 00", state); end
    tick();
    tick();
    rst_n = 1'b1;
    wait_until(cyc + 5);
  endtask

  task automatic test_manual_up();
    int base, wbase, n0;
    logic [1:0] exp_count;
    logic       exp_wrap;
    sw_auto = 1'b0;
    sw_dir  = 1'b0;
    sw_hold = 1'b0;
    wbase   = wrap_cnt;
    for (int p = 0; p < 4; p++) begin
      base      = step_cnt;
      n0        = cyc;
      exp_count = 2'((p + 1) % 4);
      exp_wrap  = (p == 3);
      btn_step  = 1'b1;
      wait_until(n0 + 6);
      checks++; if (step_pulse !== 1'b0) begin errors++; $display("[TB] FAIL manual_early_step%0d: got %b expected 0", p, step_pulse); end
      tick();
      checks++; if (step_pulse !== 1'b1) begin errors++; $display("[TB] FAIL manual_step%0d: got %b expected 1", p, step_pulse); end
      checks++; if (wrap_pulse !== exp_wrap) begin errors++; $display("[TB] FAIL manual_wrap%0d: got %b expected %b", p, wrap_pulse, exp_wrap); end
      checks++; if (dir_out !== 1'b0) begin errors++; $display("[TB] FAIL manual_dir%0d: got %b expected 0", p, dir_out); end
      tick();
      checks++; if (count !== exp_count) begin errors++; $display("[TB] FAIL manual_count%0d: got %0d expected %0d", p, count, exp_count); end
      wait_until(n0 + 10);
      btn_step = 1'b0;
      wait_until(n0 + 20);
      checks++; if (step_cnt - base !== 1) begin errors++; $display("[TB] FAIL manual_nsteps%0d: got %0d expected 1", p, step_cnt - base); end
    end
    checks++; if (wrap_cnt - wbase !== 1) begin errors++; $display("[TB] FAIL manual_nwraps: got %0d expected 1", wrap_cnt - wbase); end
  endtask

  task automatic test_auto_down();
    int n0;
    logic [1:0] exp_count;
    logic       exp_wrap;
    n0      = cyc;
    sw_dir  = 1'b1;
    sw_auto = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_count = 2'(3 - k);
      exp_wrap  = (k == 0);
      wait_until(n0 + 9 + 8 * k);
      checks++; if (step_pulse !== 1'b0) begin errors++; $display("[TB] FAIL auto_pre_step%0d: got %b expected 0", k, step_pulse); end
      tick();
      checks++; if (step_pulse !== 1'b1) begin errors++; $display("[TB] FAIL auto_step%0d: got %b expected 1", k, step_pulse); end
      checks++; if (wrap_pulse !== exp_wrap) begin errors++; $display("[TB] FAIL auto_wrap%0d: got %b expected %b", k, wrap_pulse, exp_wrap); end
      checks++; if (dir_out !== 1'b1) begin errors++; $display("[TB] FAIL auto_dir%0d: got %b expected 1", k, dir_out); end
      tick();
      checks++; if (count !== exp_count) begin errors++; $display("[TB] FAIL auto_count%0d: got %0d expected %0d", k, count, exp_count); end
    end
    sw_auto = 1'b0;
    sw_dir  = 1'b0;
    wait_until(n0 + 45);
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL auto_exit_state: got %b expected 00", state); end
  endtask

  task automatic test_bounce();
    int base, wbase, n0;
    base  = step_cnt;
    wbase = wrap_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      tick();
      tick();
    end
    checks++; if (step_cnt - base !== 0) begin errors++; $display("[TB] FAIL bounce_during: got %0d steps expected 0", step_cnt - base); end
    n0       = cyc;
    btn_step = 1'b1;
    wait_until(n0 + 10);
    btn_step = 1'b0;
    wait_until(n0 + 30);
    checks++; if (step_cnt - base !== 1) begin errors++; $display("[TB] FAIL bounce_steps: got %0d expected 1", step_cnt - base); end
    checks++; if (count !== 2'd1) begin errors++; $display("[TB] FAIL bounce_count: got %0d expected 1", count); end
    checks++; if (wrap_cnt - wbase !== 0) begin errors++; $display("[TB] FAIL bounce_wraps: got %0d expected 0", wrap_cnt - wbase); end
  endtask

  task automatic test_hold_resume();
    int n0, base;
    n0      = cyc;
    sw_dir  = 1'b0;
    sw_auto = 1'b1;
    // AUTO from n0+3 with prescaler 0, so the prescaler is 5 at n0+8,
    // the first HOLD cycle when sw_hold rises at n0+5.
    wait_until(n0 + 5);
    sw_hold = 1'b1;
    wait_until(n0 + 8);
    base = step_cnt;
    checks++; if (state !== 2'b10) begin errors++; $display("[TB] FAIL hold_state: got %b expected 10", state); end
    wait_until(n0 + 25);
    sw_hold = 1'b0;
    wait_until(n0 + 28);
    checks++; if (step_cnt - base !== 0) begin errors++; $display("[TB] FAIL hold_steps: got %0d expected 0", step_cnt - base); end
    checks++; if (state !== 2'b01) begin errors++; $display("[TB] FAIL hold_exit_state: got %b expected 01", state); end
    wait_until(n0 + 29);
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("[TB] FAIL hold_resume_early: got %b expected 0", step_pulse); end
    tick();
    checks++; if (step_pulse !== 1'b1) begin errors++; $display("[TB] FAIL hold_resume_step: got %b expected 1", step_pulse); end
    tick();
    checks++; if (count !== 2'd2) begin errors++; $display("[TB] FAIL hold_count: got %0d expected 2", count); end
    sw_auto = 1'b0;
    wait_until(n0 + 40);
    checks++; if (step_cnt - base !== 1) begin errors++; $display("[TB] FAIL hold_total_steps: got %0d expected 1", step_cnt - base); end
  endtask

  task automatic test_ignored_press();
    int n0, base;
    n0      = cyc;
    base    = step_cnt;
    sw_hold = 1'b1;
    wait_until(n0 + 5);
    btn_step = 1'b1;
    wait_until(n0 + 10);
    checks++; if (state !== 2'b10) begin errors++; $display("[TB] FAIL ignored_state: got %b expected 10", state); end
    wait_until(n0 + 15);
    btn_step = 1'b0;
    wait_until(n0 + 25);
    sw_hold = 1'b0;
    wait_until(n0 + 40);
    checks++; if (step_cnt - base !== 0) begin errors++; $display("[TB] FAIL ignored_steps: got %0d expected 0", step_cnt - base); end
    checks++; if (count !== 2'd2) begin errors++; $display("[TB] FAIL ignored_count: got %0d expected 2", count); end
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL ignored_exit_state: got %b expected 00", state); end
  endtask

  task automatic test_reset_midrun();
    int n0, r0, base;
    n0      = cyc;
    sw_dir  = 1'b0;
    sw_auto = 1'b1;
    wait_until(n0 + 7);
    checks++; if (state !== 2'b01) begin errors++; $display("[TB] FAIL midrun_pre_state: got %b expected 01", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("[TB] FAIL midrun_step: got %b expected 0", step_pulse); end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("[TB] FAIL midrun_wrap: got %b expected 0", wrap_pulse); end
    checks++; if (dir_out !== 1'b0) begin errors++; $display("[TB] FAIL midrun_dir: got %b expected 0", dir_out); end
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL midrun_count: got %0d expected 0", count); end
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL midrun_state: got %b expected 00", state); end
    tick();
    tick();
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL midrun_held_state: got %b expected 00", state); end
    base  = step_cnt;
    r0    = cyc;
    rst_n = 1'b1;
    wait_until(r0 + 2);
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL midrun_post_state: got %b expected 00", state); end
    wait_until(r0 + 3);
    checks++; if (step_cnt - base !== 0) begin errors++; $display("[TB] FAIL midrun_post_steps: got %0d expected 0", step_cnt - base); end
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL midrun_post_count: got %0d expected 0", count); end
    sw_auto = 1'b0;
    wait_until(r0 + 12);
  endtask

  task automatic test_back_to_back();
    checks++; if (consec_cnt !== 0) begin errors++; $display("[TB] FAIL back_to_back: got %0d consecutive strobes expected 0", consec_cnt); end
  endtask

  initial begin
    test_reset();
    test_manual_up();
    test_auto_down();
    test_bounce();
    test_hold_resume();
    test_ignored_press();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
